nibbler_control: RTL and testbench

Fetch/execute sequencer for the Nibbler 4-bit CPU. It owns the 12-bit program counter (`direccion`), the instruction register and the `fase` signal, and it drives the datapath control strobes (accumulator, ALU, flags, data RAM, I/O). It fetches one- or two-byte instructions from program memory with a ready handshake, and resolves conditional jumps from the `notCarry` and `notZero` flags.

---
 rtl/nibbler_pkg.sv | 26 ++
 rtl/nibbler_decoder.sv | 55 +++++
 rtl/nibbler_control.sv | 90 +++++++++
 tb/tb_nibbler_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// Shared types for the Nibbler 4-bit CPU control path: opcodes, sequencer states, ALU selects.
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_JC   = 4'h0, OP_JNC  = 4'h1, OP_CMPI = 4'h2, OP_CMPM = 4'h3,
    OP_LIT  = 4'h4, OP_IN   = 4'h5, OP_LD   = 4'h6, OP_ST   = 4'h7,
    OP_JZ   = 4'h8, OP_JNZ  = 4'h9, OP_ADDI = 4'hA, OP_ADDM = 4'hB,
    OP_JMP  = 4'hC, OP_OUT  = 4'hD, OP_NORI = 4'hE, OP_NORM = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH,
    FETCH2,
    EXEC
  } state_e;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_NOR  = 2'b10;
  localparam logic [1:0] ALU_CMP  = 2'b11;

  function automatic logic is_two_byte(opcode_e op);
    return !(op inside {OP_CMPI, OP_LIT, OP_ADDI, OP_NORI});
  endfunction

endpackage

// File: rtl/nibbler_decoder.sv
// Combinational strobe and jump decode; everything is quiet outside EXEC.
module nibbler_decoder
  import nibbler_pkg::*;
(
  input  opcode_e     op_i,
  input  state_e      state_i,
  input  logic        not_carry_i,
  input  logic        not_zero_i,
  output logic        acc_we_o,
  output logic        flags_we_o,
  output logic [1:0]  alu_sel_o,
  output logic        src_mem_o,
  output logic        ram_we_o,
  output logic        out_we_o,
  output logic        in_re_o,
  output logic        jump_taken_o
);

  always_comb begin
    acc_we_o     = 1'b0;
    flags_we_o   = 1'b0;
    alu_sel_o    = ALU_PASS;
    src_mem_o    = 1'b0;
    ram_we_o     = 1'b0;
    out_we_o     = 1'b0;
    in_re_o      = 1'b0;
    jump_taken_o = 1'b0;
    if (state_i == EXEC) begin
      unique case (op_i)
        OP_JC:   jump_taken_o = ~not_carry_i;
        OP_JNC:  jump_taken_o = not_carry_i;
        OP_JZ:   jump_taken_o = ~not_zero_i;
        OP_JNZ:  jump_taken_o = not_zero_i;
        OP_JMP:  jump_taken_o = 1'b1;
        OP_LIT:  acc_we_o = 1'b1;
        OP_LD:   begin acc_we_o = 1'b1; src_mem_o = 1'b1; end
        OP_IN:   begin acc_we_o = 1'b1; src_mem_o = 1'b1; in_re_o = 1'b1; end
        OP_ST:   ram_we_o = 1'b1;
        OP_OUT:  out_we_o = 1'b1;
        OP_CMPI: begin flags_we_o = 1'b1; alu_sel_o = ALU_CMP; end
        OP_CMPM: begin flags_we_o = 1'b1; alu_sel_o = ALU_CMP; src_mem_o = 1'b1; end
        OP_ADDI: begin acc_we_o = 1'b1; flags_we_o = 1'b1; alu_sel_o = ALU_ADD; end
        OP_ADDM: begin
          acc_we_o = 1'b1; flags_we_o = 1'b1; alu_sel_o = ALU_ADD; src_mem_o = 1'b1;
        end
        OP_NORI: begin acc_we_o = 1'b1; flags_we_o = 1'b1; alu_sel_o = ALU_NOR; end
        OP_NORM: begin
          acc_we_o = 1'b1; flags_we_o = 1'b1; alu_sel_o = ALU_NOR; src_mem_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nibbler_control.sv
// Nibbler fetch/execute sequencer: owns PC, instruction register, operand low byte and phase.
module nibbler_control
  import nibbler_pkg::*;
#(
  parameter logic [11:0] RESET_VECTOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  prog,
  input  logic        prog_ready,
  input  logic        notCarry,
  input  logic        notZero,
  output logic [11:0] direccion,
  output logic        fase,
  output logic [3:0]  operand,
  output logic [11:0] data_addr,
  output logic        acc_we,
  output logic        flags_we,
  output logic [1:0]  alu_sel,
  output logic        src_mem,
  output logic        ram_we,
  output logic        out_we,
  output logic        in_re
);

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  lo_q, lo_d;
  logic        jump_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    lo_d    = lo_q;
    unique case (state_q)
      FETCH: if (prog_ready) begin
        ir_d    = prog;
        pc_d    = pc_q + 12'd1;
        state_d = is_two_byte(opcode_e'(prog[7:4])) ? FETCH2 : EXEC;
      end
      FETCH2: if (prog_ready) begin
        lo_d    = prog;
        pc_d    = pc_q + 12'd1;
        state_d = EXEC;
      end
      EXEC: begin
        if (jump_taken) pc_d = {ir_q[3:0], lo_q};
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  nibbler_decoder u_decoder (
    .op_i         (opcode_e'(ir_q[7:4])),
    .state_i      (state_q),
    .not_carry_i  (notCarry),
    .not_zero_i   (notZero),
    .acc_we_o     (acc_we),
    .flags_we_o   (flags_we),
    .alu_sel_o    (alu_sel),
    .src_mem_o    (src_mem),
    .ram_we_o     (ram_we),
    .out_we_o     (out_we),
    .in_re_o      (in_re),
    .jump_taken_o (jump_taken)
  );

  assign direccion = pc_q;
  assign fase      = (state_q == EXEC);
  assign operand   = ir_q[3:0];
  assign data_addr = {ir_q[3:0], lo_q};

endmodule

// File: tb/tb_nibbler_control.sv
// Self-checking bench for nibbler_control: instruction-level reference model plus directed pins.
`timescale 1ns/100ps
module tb_nibbler_control;

  logic        clk = 1'b1;
  logic        reset;
  logic [7:0]  prog;
  logic        prog_ready;
  logic        notCarry;
  logic        notZero;
  logic [11:0] direccion;
  logic        fase;
  logic [3:0]  operand;
  logic [11:0] data_addr;
  logic        acc_we, flags_we, src_mem, ram_we, out_we, in_re;
  logic [1:0]  alu_sel;

  always #5 clk = ~clk;

  nibbler_control #(.RESET_VECTOR(12'h000)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog       (prog),
    .prog_ready (prog_ready),
    .notCarry   (notCarry),
    .notZero    (notZero),
    .direccion  (direccion),
    .fase       (fase),
    .operand    (operand),
    .data_addr  (data_addr),
    .acc_we     (acc_we),
    .flags_we   (flags_we),
    .alu_sel    (alu_sel),
    .src_mem    (src_mem),
    .ram_we     (ram_we),
    .out_we     (out_we),
    .in_re      (in_re)
  );

  // strobe vector order: acc_we, flags_we, alu_sel[1:0], src_mem, ram_we, out_we, in_re
  logic [7:0] strobes;
  assign strobes = {acc_we, flags_we, alu_sel, src_mem, ram_we, out_we, in_re};

  typedef struct {
    logic [11:0] dir;
    logic        fase;
    logic [7:0]  strb;
    logic        chk_op;
    logic [3:0]  opnd;
    logic [11:0] daddr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int errors = 0;
  int checks = 0;
  int cycles = 0;

  logic [11:0] m_pc;
  logic [7:0]  m_lo;

  logic [2:0]  fase_hist = '0;
  logic [7:0]  last_strb = '0;
  logic [3:0]  last_opnd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] exp_strobes(input logic [3:0] op);
    case (op)
      4'h2:    return 8'b0_1_11_0_000;
      4'h3:    return 8'b0_1_11_1_000;
      4'h4:    return 8'b1_0_00_0_000;
      4'h5:    return 8'b1_0_00_1_001;
      4'h6:    return 8'b1_0_00_1_000;
      4'h7:    return 8'b0_0_00_0_100;
      4'hA:    return 8'b1_1_01_0_000;
      4'hB:    return 8'b1_1_01_1_000;
      4'hD:    return 8'b0_0_00_0_010;
      4'hE:    return 8'b1_1_10_0_000;
      4'hF:    return 8'b1_1_10_1_000;
      default: return 8'b0;
    endcase
  endfunction

  task automatic push(input logic [11:0] d, input logic f, input logic [7:0] s,
                      input logic co, input logic [3:0] o, input logic [11:0] da);
    exp_t x;
    x.dir = d; x.fase = f; x.strb = s; x.chk_op = co; x.opnd = o; x.daddr = da;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic fetch_byte(input logic [7:0] b, input int stalls);
    for (int i = 0; i < stalls; i++) begin
      prog_ready = 1'b0;
      prog       = 8'($urandom);
      push(m_pc, 1'b0, 8'h00, 1'b0, 4'h0, 12'h000);
      step();
    end
    prog_ready = 1'b1;
    prog       = b;
    push(m_pc, 1'b0, 8'h00, 1'b0, 4'h0, 12'h000);
    step();
    m_pc = m_pc + 12'd1;
  endtask

  task automatic run_instr(input logic [7:0] b0, input logic [7:0] b1, input int s0,
                           input int s1, input logic nc, input logic nz);
    logic [3:0] op;
    logic       two;
    logic       taken;
    op  = b0[7:4];
    two = !(op inside {4'h2, 4'h4, 4'hA, 4'hE});
    fetch_byte(b0, s0);
    if (two) begin
      fetch_byte(b1, s1);
      m_lo = b1;
    end
    notCarry   = nc;
    notZero    = nz;
    prog_ready = 1'($urandom);
    prog       = 8'($urandom);
    push(m_pc, 1'b1, exp_strobes(op), 1'b1, b0[3:0], {b0[3:0], m_lo});
    step();
    case (op)
      4'h0:    taken = !nc;
      4'h1:    taken = nc;
      4'h8:    taken = !nz;
      4'h9:    taken = nz;
      4'hC:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (taken) m_pc = {b0[3:0], m_lo};
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    m_pc  = 12'h000;
    m_lo  = 8'h00;
  endtask

  always @(negedge clk) begin
    fase_hist <= {fase_hist[1:0], fase};
    if (fase) begin
      last_strb <= strobes;
      last_opnd <= operand;
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("direccion", 32'(direccion), 32'(e.dir));
      chk("fase", 32'(fase), 32'(e.fase));
      chk("strobes", 32'(strobes), 32'(e.strb));
      if (e.chk_op) begin
        chk("operand", 32'(operand), 32'(e.opnd));
        chk("data_addr", 32'(data_addr), 32'(e.daddr));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    reset = 1'b1; prog = 8'h00; prog_ready = 1'b0; notCarry = 1'b1; notZero = 1'b1;
    m_pc = 12'h000; m_lo = 8'h00;
    #1 reset = 1'b0;
    #0.5;
    chk("rst_direccion", 32'(direccion), 32'h000);
    chk("rst_fase", 32'(fase), 32'h0);
    chk("rst_strobes", 32'(strobes), 32'h00);
    chk("rst_operand", 32'(operand), 32'h0);
    chk("rst_data_addr", 32'(data_addr), 32'h000);
    #0.5 reset = 1'b1;

    run_instr(8'h4F, 8'h00, 0, 0, 1'b1, 1'b1);
    chk("lit_pc", 32'(direccion), 32'h001);
    chk("lit_strobes", 32'(last_strb), 32'h80);
    chk("lit_operand", 32'(last_opnd), 32'hF);

    run_instr(8'hC3, 8'hA5, 0, 0, 1'b1, 1'b1);
    chk("jmp_fase_seq", 32'(fase_hist), 32'b001);
    chk("jmp_pc", 32'(direccion), 32'h3A5);

    reset_pulse();
    run_instr(8'h81, 8'h20, 0, 0, 1'b1, 1'b1);
    chk("jz_not_taken_pc", 32'(direccion), 32'h002);
    reset_pulse();
    run_instr(8'h81, 8'h20, 0, 0, 1'b1, 1'b0);
    chk("jz_taken_pc", 32'(direccion), 32'h120);

    c0 = cycles;
    run_instr(8'h4F, 8'h00, 3, 0, 1'b1, 1'b1);
    chk("stall_cycles", 32'(cycles - c0), 32'd5);

    run_instr(8'hCF, 8'hFF, 0, 0, 1'b0, 1'b0);
    chk("pc_at_fff", 32'(direccion), 32'hFFF);
    run_instr(8'h47, 8'h00, 0, 0, 1'b1, 1'b1);
    chk("pc_wrap", 32'(direccion), 32'h000);

    // abort an ST while it waits in FETCH2
    fetch_byte(8'h71, 0);
    prog_ready = 1'b0;
    #1 reset = 1'b0;
    #0.5;
    chk("abort_direccion", 32'(direccion), 32'h000);
    chk("abort_ram_we", 32'(ram_we), 32'h0);
    chk("abort_fase", 32'(fase), 32'h0);
    #0.5 reset = 1'b1;
    m_pc = 12'h000;
    m_lo = 8'h00;
    run_instr(8'h4A, 8'h00, 1, 0, 1'b1, 1'b1);

    for (int n = 0; n < 400; n++) begin
      run_instr(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
